// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program-counter generator for the RV core.
//
// Holds the fetch address and picks the next PC from one of four sources:
// sequential step, taken branch/jump, trap entry or trap return. The PC of a
// trapping or faulting instruction is saved in epc. A misaligned branch target
// becomes a redirect to TRAP_VECTOR. The block also counts retired
// instructions. All state updates on the falling edge of clk.
//
// Ports
//   clk            in   core clock (state updates on the falling edge)
//   reset_n        in   asynchronous active-low reset
//   stall          in   hold PC while a multi-cycle instruction runs
//   branch_taken   in   redirect to branch_target
//   branch_target  in   branch/jump destination [XLEN]
//   trap           in   exception/interrupt entry (highest priority)
//   trap_ret       in   return from trap to epc
//   instr_addr     out  registered fetch address [XLEN]
//   pc_valid       out  instr_addr is a real fetch (0 in the reset cycle)
//   epc            out  PC of last trapping/faulting instruction [XLEN]
//   misalign_fault out  one-cycle pulse after a misaligned redirect
//   retired_count  out  instructions retired since reset [CNT_W]
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned       ILEN         = 4,
    parameter int unsigned       ALIGN_BITS   = 2,
    parameter int unsigned       CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             trap,
    input  logic             trap_ret,
    output logic [XLEN-1:0]  instr_addr,
    output logic             pc_valid,
    output logic [XLEN-1:0]  epc,
    output logic             misalign_fault,
    output logic [CNT_W-1:0] retired_count
);

    // Low target bits that must be zero. An empty mask (ALIGN_BITS=0) turns
    // the alignment check off entirely.
    localparam logic [XLEN-1:0] ALIGN_MASK =
        XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [XLEN-1:0]  pc_q,    pc_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  epc_q,   epc_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             retire_s;
    logic             misaligned_s;

    assign misaligned_s = |(branch_target & ALIGN_MASK);

    // Next-state selection. The first matching source wins.
    always_comb begin
        pc_d     = pc_q;
        valid_d  = valid_q;
        epc_d    = epc_q;
        fault_d  = 1'b0;
        retire_s = 1'b0;
        if (!valid_q) begin
            // First edge after reset: the reset-vector fetch becomes valid
            // and the PC holds. Nothing retires on this edge.
            valid_d = 1'b1;
        end else if (trap) begin
            pc_d  = TRAP_VECTOR;
            epc_d = pc_q;
        end else if (stall) begin
            // Hold everything. A pending branch or trap_ret waits for the
            // stall to end.
            pc_d = pc_q;
        end else if (trap_ret) begin
            pc_d     = epc_q;
            retire_s = 1'b1;
        end else if (branch_taken && misaligned_s) begin
            pc_d    = TRAP_VECTOR;
            epc_d   = pc_q;
            fault_d = 1'b1;
        end else if (branch_taken) begin
            pc_d     = branch_target;
            retire_s = 1'b1;
        end else begin
            // Wraps modulo 2^XLEN.
            pc_d     = pc_q + XLEN'(ILEN);
            retire_s = 1'b1;
        end
    end

    // Retired-instruction counter next state (wraps modulo 2^CNT_W).
    always_comb begin
        cnt_d = cnt_q;
        if (retire_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers, clocked on the falling edge with asynchronous reset.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            epc_q   <= {XLEN{1'b0}};
            fault_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            epc_q   <= epc_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_addr     = pc_q;
    assign pc_valid       = valid_q;
    assign epc            = epc_q;
    assign misalign_fault = fault_q;
    assign retired_count  = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- directed bench for pc_gen with a queue-based scoreboard.
// Three instances are used: dut0 has the default parameters, dut1 has
// ALIGN_BITS=1, and dut2 has RESET_VECTOR=FFFF_FFFC and CNT_W=4.
// Each stimulus step pushes the hand-computed state expected after the next
// falling edge. A monitor pops and compares that state on the following rising
// edge.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        r0 = 1'b1, r1 = 1'b1, r2 = 1'b1;
    logic        stall = 1'b0, br = 1'b0, trap = 1'b0, tret = 1'b0;
    logic [31:0] tgt = 32'h0;

    logic [31:0] pc0, epc0, pc1, epc1, pc2, epc2;
    logic        v0, mf0, v1, mf1, v2, mf2;
    logic [63:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        int          dut;
        string       name;
        logic [31:0] pc;
        logic        v;
        logic [31:0] epc;
        logic        mf;
        logic [63:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [31:0] a_pc, a_epc;
    logic        a_v, a_mf;
    logic [63:0] a_cnt;

    always #5 clk = ~clk;

    pc_gen dut0 (
        .clk(clk), .reset_n(r0), .stall(stall), .branch_taken(br),
        .branch_target(tgt), .trap(trap), .trap_ret(tret),
        .instr_addr(pc0), .pc_valid(v0), .epc(epc0),
        .misalign_fault(mf0), .retired_count(cnt0)
    );

    pc_gen #(.ALIGN_BITS(1)) dut1 (
        .clk(clk), .reset_n(r1), .stall(stall), .branch_taken(br),
        .branch_target(tgt), .trap(trap), .trap_ret(tret),
        .instr_addr(pc1), .pc_valid(v1), .epc(epc1),
        .misalign_fault(mf1), .retired_count(cnt1)
    );

    pc_gen #(.RESET_VECTOR(32'hFFFF_FFFC), .CNT_W(4)) dut2 (
        .clk(clk), .reset_n(r2), .stall(stall), .branch_taken(br),
        .branch_target(tgt), .trap(trap), .trap_ret(tret),
        .instr_addr(pc2), .pc_valid(v2), .epc(epc2),
        .misalign_fault(mf2), .retired_count(cnt2)
    );

    // Edge counter: number of falling edges seen so far.
    always @(negedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compare every entry that falls due this cycle.
    always @(posedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            case (mon_e.dut)
                0: begin a_pc = pc0; a_v = v0; a_epc = epc0; a_mf = mf0; a_cnt = cnt0; end
                1: begin a_pc = pc1; a_v = v1; a_epc = epc1; a_mf = mf1; a_cnt = cnt1; end
                default: begin a_pc = pc2; a_v = v2; a_epc = epc2; a_mf = mf2; a_cnt = 64'(cnt2); end
            endcase
            checks++;
            if (a_pc !== mon_e.pc || a_v !== mon_e.v || a_epc !== mon_e.epc ||
                a_mf !== mon_e.mf || a_cnt !== mon_e.cnt || mon_e.due != cyc) begin
                errors++;
                $display("FAIL %s (dut%0d): got pc=%h v=%b epc=%h mf=%b cnt=%0d, expected pc=%h v=%b epc=%h mf=%b cnt=%0d",
                         mon_e.name, mon_e.dut, a_pc, a_v, a_epc, a_mf, a_cnt,
                         mon_e.pc, mon_e.v, mon_e.epc, mon_e.mf, mon_e.cnt);
            end
        end
    end

    // Asynchronous reset: dut0 outputs must reach reset values without a clock edge.
    always @(negedge r0) begin
        #1;
        checks++;
        if (pc0 !== 32'h0 || v0 !== 1'b0 || epc0 !== 32'h0 || mf0 !== 1'b0 || cnt0 !== 64'h0) begin
            errors++;
            $display("FAIL async_reset: got pc=%h v=%b epc=%h mf=%b cnt=%0d, expected all zero",
                     pc0, v0, epc0, mf0, cnt0);
        end
    end

    // Drive one cycle of inputs. The expected state after the next falling
    // edge is queued for the monitor.
    task automatic step(input int dut, input string name, input logic [2:0] rst,
                        input logic st, input logic b, input logic [31:0] t,
                        input logic tr, input logic trr,
                        input logic [31:0] e_pc, input logic e_v,
                        input logic [31:0] e_epc, input logic e_mf,
                        input logic [63:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        {r2, r1, r0} = rst;
        stall = st; br = b; tgt = t; trap = tr; tret = trr;
        e.due = cyc + 1; e.dut = dut; e.name = name;
        e.pc = e_pc; e.v = e_v; e.epc = e_epc; e.mf = e_mf; e.cnt = e_cnt;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        // dut0: reset state, then release.
        step(0, "reset",   3'b000, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 64'd0);
        step(0, "t1_hold", 3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 32'h0,  1'b0, 64'd0);
        step(0, "t1_seq4", 3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h4,   1'b1, 32'h0,  1'b0, 64'd1);
        step(0, "t1_seq8", 3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h8,   1'b1, 32'h0,  1'b0, 64'd2);
        step(0, "t1_seqC", 3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'hC,   1'b1, 32'h0,  1'b0, 64'd3);
        step(0, "t1_seq10",3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h10,  1'b1, 32'h0,  1'b0, 64'd4);
        // Stall with a pending branch.
        for (int i = 0; i < 3; i++)
            step(0, "t2_stall", 3'b001, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0, 1'b0, 64'd4);
        step(0, "t2_branch", 3'b001, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h40,  1'b1, 32'h0,  1'b0, 64'd5);
        // Misaligned branch target.
        step(0, "t3_br20",   3'b001, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h20,  1'b1, 32'h0,  1'b0, 64'd6);
        step(0, "t3_fault",  3'b001, 1'b0, 1'b1, 32'h42, 1'b0, 1'b0, 32'h100, 1'b1, 32'h20, 1'b1, 64'd6);
        step(0, "t3_clear",  3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h104, 1'b1, 32'h20, 1'b0, 64'd7);
        // Trap overriding stall, branch and trap_ret, then return.
        step(0, "t4_br80",   3'b001, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h80,  1'b1, 32'h20, 1'b0, 64'd8);
        step(0, "t4_trap",   3'b001, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 64'd8);
        step(0, "t4_seq",    3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h104, 1'b1, 32'h80, 1'b0, 64'd9);
        step(0, "t4_stlret", 3'b001, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h104, 1'b1, 32'h80, 1'b0, 64'd9);
        step(0, "t4_ret",    3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80,  1'b1, 32'h80, 1'b0, 64'd10);
        // Reset in the middle of a branch; the branch is discarded.
        step(0, "t6_reset",  3'b000, 1'b0, 1'b1, 32'h200,1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 64'd0);
        step(0, "t6_hold",   3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 32'h0,  1'b0, 64'd0);
        step(0, "t6_seq4",   3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h4,   1'b1, 32'h0,  1'b0, 64'd1);
        step(0, "t6_seq8",   3'b001, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h8,   1'b1, 32'h0,  1'b0, 64'd2);

        // dut1 (ALIGN_BITS=1): target 0x42 is legal, 0x43 is not.
        step(1, "d1_reset",  3'b000, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 64'd0);
        step(1, "d1_hold",   3'b010, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 32'h0,  1'b0, 64'd0);
        for (int k = 1; k <= 8; k++)
            step(1, "d1_seq", 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'(4 * k), 1'b1, 32'h0, 1'b0, 64'(k));
        step(1, "d1_br42",   3'b010, 1'b0, 1'b1, 32'h42, 1'b0, 1'b0, 32'h42,  1'b1, 32'h0,  1'b0, 64'd9);
        step(1, "d1_fault43",3'b010, 1'b0, 1'b1, 32'h43, 1'b0, 1'b0, 32'h100, 1'b1, 32'h42, 1'b1, 64'd9);
        step(1, "d1_clear",  3'b010, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h104, 1'b1, 32'h42, 1'b0, 64'd10);

        // dut2: PC wraps past all-ones, 4-bit counter wraps after 16.
        step(2, "d2_reset",  3'b000, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 64'd0);
        step(2, "d2_hold",   3'b100, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b0, 64'd0);
        for (int k = 1; k <= 17; k++)
            step(2, "d2_wrap", 3'b100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'(4 * (k - 1)), 1'b1, 32'h0, 1'b0, 64'(k % 16));
        step(2, "d2_trap",   3'b100, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 1'b1, 32'h40, 1'b0, 64'd1);

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
